// File: rtl/pipeline_control.sv
// pipeline_control: stall-vector generation, multi-cycle EX sequencing and
// exception flush/redirect for the five pipeline latches plus PC.
// Optional feature: define STALL_WATCHDOG_EN to enable the sticky stall
// watchdog (stall_timeout); otherwise stall_timeout is tied low.
module pipeline_control #(
  parameter int unsigned COUNT_WIDTH    = 6,
  parameter int unsigned WATCHDOG_LIMIT = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_request_id,
  input  logic                   stall_request_ex,
  input  logic                   stall_request_mem,
  input  logic                   ex_multicycle_start,
  input  logic [COUNT_WIDTH-1:0] ex_multicycle_cycles,
  output logic                   ex_multicycle_done,
  input  logic                   exception_request,
  input  logic [31:0]            exception_target,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   stall_timeout
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_FREEZE = 2'd2,
    S_FLUSH  = 2'd3
  } state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   flush_q, flush_d;
  logic [31:0]            new_pc_q, new_pc_d;
  logic                   exc_accept;
  logic                   start_accept;
  logic [5:0]             stall_vec;

  // Qualify exception and multi-cycle start against the current state.
  always_comb begin
    exc_accept   = exception_request && ((state_q == S_RUN) || (state_q == S_HOLD));
    start_accept = (state_q == S_RUN) && ex_multicycle_start &&
                   (ex_multicycle_cycles != '0) && !exception_request;
  end

  // Next-state, counter, redirect and registered-pulse logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    unique case (state_q)
      S_RUN: begin
        if (exc_accept) begin
          state_d  = S_FREEZE;
          cnt_d    = '0;
          new_pc_d = exception_target;
        end else if (start_accept) begin
          // The start cycle itself is the first of the N stall cycles.
          cnt_d = ex_multicycle_cycles - COUNT_WIDTH'(1);
          if (cnt_d != '0) state_d = S_HOLD;
          else             done_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (exc_accept) begin
          state_d  = S_FREEZE;
          cnt_d    = '0;
          new_pc_d = exception_target;
        end else begin
          cnt_d = cnt_q - COUNT_WIDTH'(1);
          if (cnt_q == COUNT_WIDTH'(1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      S_FREEZE: begin
        state_d = S_FLUSH;
        flush_d = 1'b1;
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stall vector: highest requesting stage wins; FREEZE/FLUSH override.
  always_comb begin
    stall_vec = STALL_NONE;
    unique case (state_q)
      S_FREEZE: stall_vec = STALL_ALL;
      S_FLUSH:  stall_vec = STALL_NONE;
      default: begin
        if (stall_request_mem)
          stall_vec = STALL_MEM;
        else if (stall_request_ex || start_accept || (state_q == S_HOLD))
          stall_vec = STALL_EX;
        else if (stall_request_id)
          stall_vec = STALL_ID;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign stall              = stall_vec;
  assign flush              = flush_q;
  assign new_pc             = new_pc_q;
  assign ex_multicycle_done = done_q;

`ifdef STALL_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WATCHDOG_LIMIT + 1);

  logic [WDW-1:0] wd_q;
  logic           timeout_q;

  // Count consecutive stalled cycles; flag sticks once the limit is hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (stall_vec == '0) begin
        wd_q <= '0;
      end else begin
        if (wd_q != WDW'(WATCHDOG_LIMIT)) wd_q <= wd_q + WDW'(1);
        if (wd_q == WDW'(WATCHDOG_LIMIT - 1)) timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed, table-driven bench for pipeline_control.
module tb_pipeline_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_request_id, stall_request_ex, stall_request_mem;
  logic        ex_multicycle_start;
  logic [5:0]  ex_multicycle_cycles;
  logic        ex_multicycle_done;
  logic        exception_request;
  logic [31:0] exception_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipeline_control #(.COUNT_WIDTH(6), .WATCHDOG_LIMIT(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .stall_request_id     (stall_request_id),
    .stall_request_ex     (stall_request_ex),
    .stall_request_mem    (stall_request_mem),
    .ex_multicycle_start  (ex_multicycle_start),
    .ex_multicycle_cycles (ex_multicycle_cycles),
    .ex_multicycle_done   (ex_multicycle_done),
    .exception_request    (exception_request),
    .exception_target     (exception_target),
    .stall                (stall),
    .flush                (flush),
    .new_pc               (new_pc),
    .stall_timeout        (stall_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        id, ex, mem, start;
    logic [5:0]  cycles;
    logic        exc;
    logic [31:0] target;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic        exp_done;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic id, logic ex, logic mem, logic start, logic [5:0] cyc,
                              logic exc, logic [31:0] tgt, logic [5:0] st, logic fl,
                              logic dn, logic [31:0] pc);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.start = start; v.cycles = cyc;
    v.exc = exc; v.target = tgt; v.exp_stall = st; v.exp_flush = fl;
    v.exp_done = dn; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall_request_id = 0; stall_request_ex = 0; stall_request_mem = 0;
    ex_multicycle_start = 0; ex_multicycle_cycles = '0;
    exception_request = 0; exception_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Sequence rows: one cycle each, checked at the falling edge.
    //               id ex mem st cyc exc tgt            stall      fl dn pc
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,            6'b000111, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,            6'b011111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // N=4
    vecs.push_back(mk(0, 0, 0, 1, 4, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // N=1
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 1, 0));
    // N=0 ignored
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,            6'b000000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // N=3 with a start during HOLD that must be ignored
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // N=10, exception on HOLD cycle 3
    vecs.push_back(mk(0, 0, 0, 1, 10, 0, 0,           6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_0180, 6'b001111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b111111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 1, 0, 32'h0000_0180));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // Exception in RUN with id request; later exceptions in FREEZE/FLUSH ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0000_0200, 6'b000111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0000_0300, 6'b111111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0000_0300, 6'b000000, 1, 0, 32'h0000_0200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    // Exception wins over a simultaneous start
    vecs.push_back(mk(0, 0, 0, 1, 4, 1, 32'h0000_0400, 6'b000000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b111111, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 1, 0, 32'h0000_0400));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0, 0));

    idle_inputs();
    reset = 1'b1;
    #12;
    check("reset_stall",   {26'd0, stall}, 32'd0);
    check("reset_flush",   {31'd0, flush}, 32'd0);
    check("reset_done",    {31'd0, ex_multicycle_done}, 32'd0);
    check("reset_new_pc",  new_pc, 32'd0);
    check("reset_timeout", {31'd0, stall_timeout}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall_request_id     = vecs[i].id;
      stall_request_ex     = vecs[i].ex;
      stall_request_mem    = vecs[i].mem;
      ex_multicycle_start  = vecs[i].start;
      ex_multicycle_cycles = vecs[i].cycles;
      exception_request    = vecs[i].exc;
      exception_target     = vecs[i].target;
      @(negedge clock);
      check($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_done",  i), {31'd0, ex_multicycle_done}, {31'd0, vecs[i].exp_done});
      if (vecs[i].exp_flush)
        check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].exp_pc);
      @(posedge clock); #1;
    end
    idle_inputs();

    // Reset asserted mid-HOLD: outputs return to reset values without a clock edge.
    ex_multicycle_start = 1; ex_multicycle_cycles = 6'd8;
    @(negedge clock);
    check("hold_start_stall", {26'd0, stall}, {26'd0, 6'b001111});
    @(posedge clock); #1;
    idle_inputs();
    @(posedge clock); #2;
    check("hold_mid_stall", {26'd0, stall}, {26'd0, 6'b001111});
    reset = 1'b1; #1;
    check("rst_hold_stall", {26'd0, stall}, 32'd0);
    check("rst_hold_done",  {31'd0, ex_multicycle_done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check($sformatf("post_rst_hold%0d_stall", c), {26'd0, stall}, 32'd0);
      check($sformatf("post_rst_hold%0d_done",  c), {31'd0, ex_multicycle_done}, 32'd0);
    end
    @(posedge clock); #1;

    // Reset asserted mid-FLUSH: flush and new_pc drop at once, no flush later.
    exception_request = 1; exception_target = 32'h0000_1234;
    @(posedge clock); #1;
    idle_inputs();
    @(posedge clock); #1;
    check("pre_rst_flush",  {31'd0, flush}, 32'd1);
    check("pre_rst_new_pc", new_pc, 32'h0000_1234);
    reset = 1'b1; #1;
    check("rst_flush_flush",  {31'd0, flush}, 32'd0);
    check("rst_flush_new_pc", new_pc, 32'd0);
    check("rst_flush_stall",  {26'd0, stall}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("post_rst_flush%0d_flush", c), {31'd0, flush}, 32'd0);
      check($sformatf("post_rst_flush%0d_stall", c), {26'd0, stall}, 32'd0);
    end
    @(posedge clock); #1;

`ifdef STALL_WATCHDOG_EN
    // Seven stalled cycles stay below the limit of 8.
    stall_request_mem = 1;
    repeat (7) @(posedge clock);
    #1 stall_request_mem = 0;
    @(negedge clock);
    check("wd_7_cycles", {31'd0, stall_timeout}, 32'd0);
    @(posedge clock); #1;
    // Eight stalled cycles trip it, and it stays set.
    stall_request_mem = 1;
    repeat (8) @(posedge clock);
    #1 stall_request_mem = 0;
    @(negedge clock);
    check("wd_8_cycles", {31'd0, stall_timeout}, 32'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("wd_sticky", {31'd0, stall_timeout}, 32'd1);
`else
    stall_request_mem = 1;
    repeat (12) @(posedge clock);
    #1 stall_request_mem = 0;
    @(negedge clock);
    check("timeout_tied_low", {31'd0, stall_timeout}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
